// File: rtl/mul_operand_gen.sv
// mul_operand_gen: streams every walking-bit (a,b) operand pair over valid/ready
// Ports: clk, rst (sync, active-high), start (begin sweep from IDLE),
//   a/b (operands), valid/ready (handshake), pat (class 0..5), busy (RUN),
//   done (one-cycle pulse after last transfer), xfer_cnt (transfers this sweep).
// MUL_GEN_TRIPLE_EN: when defined, adds walking 101s/010s classes (4, 5).
module mul_operand_gen #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         valid,
  output logic [2:0]   pat,
  output logic         busy,
  output logic         done,
  output logic [31:0]  xfer_cnt
);
  localparam int CW = $clog2(W + 1);
`ifdef MUL_GEN_TRIPLE_EN
  localparam logic [2:0] LAST_PAT = 3'd5;
`else
  localparam logic [2:0] LAST_PAT = 3'd3;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_state;
  logic [W-1:0] r_a, r_b, w_a, w_b;
  logic [2:0] r_pat, w_pat;
  logic [CW-1:0] r_i, r_j, w_i, w_j;
  logic r_valid, w_valid, r_done, w_done, w_xfer, w_fill;
  logic [31:0] r_cnt, w_cnt;
  // Odd classes are the bitwise complement of the preceding even class,
  // so the seed is a small low-bit motif optionally inverted.
  function automatic logic [W-1:0] seed(input logic [2:0] p);
    logic [W-1:0] base;
    base = p[2] ? W'(5) : p[1] ? W'(3) : W'(1);
    return p[0] ? ~base : base;
  endfunction
  assign w_xfer = r_valid && ready;
  assign w_fill = r_pat[0];
  always_comb begin
    w_state = r_state;
    w_a = r_a;
    w_b = r_b;
    w_pat = r_pat;
    w_i = r_i;
    w_j = r_j;
    w_valid = r_valid;
    w_done = 1'b0;
    w_cnt = r_cnt;
    if (r_state == IDLE) begin
      if (start) begin
        w_state = RUN;
        w_a = seed(3'd0);
        w_b = seed(3'd0);
        w_pat = 3'd0;
        w_i = '0;
        w_j = '0;
        w_valid = 1'b1;
        w_cnt = '0;
      end
    end else if (w_xfer) begin
      w_cnt = r_cnt + 32'd1;
      if (r_j != CW'(W - 1)) begin
        w_j = r_j + CW'(1);
        w_b = {r_b[W-2:0], w_fill};
      end else if (r_i != CW'(W - 1)) begin
        w_j = '0;
        w_i = r_i + CW'(1);
        w_b = seed(r_pat);
        w_a = {r_a[W-2:0], w_fill};
      end else if (r_pat != LAST_PAT) begin
        w_j = '0;
        w_i = '0;
        w_pat = r_pat + 3'd1;
        w_a = seed(r_pat + 3'd1);
        w_b = seed(r_pat + 3'd1);
      end else begin
        w_state = IDLE;
        w_j = '0;
        w_i = '0;
        w_valid = 1'b0;
        w_done = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_pat <= '0;
      r_i <= '0;
      r_j <= '0;
      r_valid <= 1'b0;
      r_done <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_a <= w_a;
      r_b <= w_b;
      r_pat <= w_pat;
      r_i <= w_i;
      r_j <= w_j;
      r_valid <= w_valid;
      r_done <= w_done;
      r_cnt <= w_cnt;
    end
  end
  assign a = r_a;
  assign b = r_b;
  assign valid = r_valid;
  assign pat = r_pat;
  assign busy = r_state == RUN;
  assign done = r_done;
  assign xfer_cnt = r_cnt;
endmodule
